demux_gate_unit: RTL and testbench
==================================

# demux_gate_unit

Parametrised, pipelined two-input logic unit that generalises the single-bit XOR/XNOR-by-demux gate to a WIDTH-bit vector with a run-time-selectable function. Each bit pair drives a 1-to-4 demux whose one-hot minterm outputs are combined according to a 4-bit truth-table opcode, so all 16 two-input functions are available: XOR, XNOR, AND, NAND, OR, NOR and the rest. Results leave through a two-stage valid/ready pipeline with a per-result population count. The block sits between an operand producer and any result consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 8, operand/result bit width; legal range 1 to 64.
- CW, $clog2(WIDTH+1), derived; width of the ones count. Do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  truth table; y[i] = op[{a[i],b[i]}].
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  gate result.
- ones  output  CW  number of 1 bits in y.

## Operation
- Input transfer happens when in_valid && in_ready at a rising edge. Output transfer happens when out_valid && out_ready.
- Stage 1 (S1) captures the per-bit minterms on transfer: m[i] = onehot4({a[i],b[i]}). It also captures op. It holds s1_valid.
- Stage 2 (S2) computes y[i] = |(m[i] & op) and ones = popcount(y). It registers both with s2_valid. out_valid = s2_valid.
- Popcount is unsigned, zero-extended to CW bits. With WIDTH=8, CW=4, and the maximum value is 8.
- Advance rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads. This is a combinational path from out_ready.
- A stage whose valid is clear and that receives no new data sets its valid to 0. Data registers may keep stale values.
- Stall hold: while out_valid && !out_ready, y and ones stay bit-stable. S1 stays stable too if it is full.
- Reset, asserted at any time including mid-stream:
  - s1_valid, s2_valid, y and ones are cleared to 0 immediately.
  - In-flight beats are discarded and never reappear.
- Reset values: out_valid=0, y=0, ones=0. After reset, in_ready=1 because both stages are empty.
- op is sampled per beat. Changing op between beats has no effect on beats already accepted.
- There is no internal state beyond the two stages. No beat is duplicated or dropped except by reset.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 in the cycle after edge k+1, i.e. 2 register stages. It can transfer at edge k+2 at the earliest.
- Throughput: 1 beat per cycle while out_ready=1.
- Backpressure:
  - With out_ready held low, the unit accepts at most 2 beats. in_ready goes low in the cycle after the second beat is captured.
  - When out_ready rises, in_ready goes high in the same cycle.
- Simultaneous events:
  - Output transfer and input transfer at the same edge with both stages full: S2 takes S1's beat, S1 takes the new beat, and no bubble is inserted.
- First edge after rst_n deassertion:
  - The unit may accept a beat; out_valid remains 0 until that beat reaches S2.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: out_valid=0, y=8'h00, ones=0, in_ready=1. Then assert rst_n=0 asynchronously mid-cycle with 2 beats in flight. Required: outputs clear before the next edge, and neither beat ever emerges.
- Functions: WIDTH=8, a=8'hF0, b=8'hCC, out_ready=1. Required results:
  - op=4'b0110 (XOR): y=8'h3C, ones=4.
  - op=4'b1001 (XNOR): y=8'hC3, ones=4.
  - op=4'b1000 (AND): y=8'hC0, ones=2.
  - op=4'b1110 (OR): y=8'hFC, ones=6.
  - Each result appears exactly 2 cycles after acceptance.
- Exhaustive single bit: WIDTH=1, sweep all 16 op values × 4 (a,b) pairs. Required: y == op[{a,b}] for every beat, and ones == y.
- Streaming: 20 back-to-back beats with out_ready=1. Required: 20 results in order, one per cycle, and in_ready constantly 1.
- Backpressure: out_ready=0 while sending 3 beats (XOR, XNOR, AND of F0/CC). Required:
  - Only 2 are accepted, and in_ready=0 after that.
  - y holds 8'h3C stable.
  - After out_ready=1, outputs are 8'h3C, 8'hC3, 8'hC0 in order with no loss.
- Extremes: a=8'hFF, b=8'hFF, op=4'b1000. Required: y=8'hFF, ones=8. Then op=4'b0000 gives y=8'h00, ones=0, and op=4'b1111 gives y=8'hFF, ones=8.

Source files
------------

// File: rtl/demux_gate_unit_if.sv
// demux_gate_unit_if: operand/result valid-ready bundle for demux_gate_unit
interface demux_gate_unit_if #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [CW-1:0]    ones;
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, ones
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, ones
    );
endinterface

// File: rtl/demux_gate_unit.sv
// demux_gate_unit: per-bit 1-to-4 demux minterms masked by a truth-table opcode, two-stage valid/ready pipeline with popcount
module demux_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH + 1)
) (
    input logic clk,
    input logic rst_n,
    demux_gate_unit_if.slave bus
);
    logic [WIDTH-1:0][3:0] m_q, m_d;
    logic [3:0]            op_q, op_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]      y_q, y_d, y_c;
    logic [CW-1:0]         ones_q, ones_d, ones_c;
    logic                  s1_load, s2_load, in_fire;
    always_comb begin
        s2_load = !s2_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
        in_fire = bus.in_valid && s1_load;
        m_d = m_q;
        y_c = '0;
        ones_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m_d[i] = in_fire ? 4'b0001 << {bus.a[i], bus.b[i]} : m_q[i];
            y_c[i] = |(m_q[i] & op_q);
            ones_c = ones_c + CW'(y_c[i]);
        end
        op_d = in_fire ? bus.op : op_q;
        s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        y_d = (s2_load && s1_valid_q) ? y_c : y_q;
        ones_d = (s2_load && s1_valid_q) ? ones_c : ones_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= '0;
            op_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            ones_q     <= '0;
        end else begin
            m_q        <= m_d;
            op_q       <= op_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            ones_q     <= ones_d;
        end
    end
    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.ones      = ones_q;
endmodule

// File: tb/tb_demux_gate_unit.sv
// tb_demux_gate_unit: directed checks of an 8-bit and a 1-bit demux_gate_unit
module tb_demux_gate_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    demux_gate_unit_if #(.WIDTH(8)) b8 ();
    demux_gate_unit_if #(.WIDTH(1)) b1 ();
    demux_gate_unit #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    demux_gate_unit #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    logic [3:0] fn_op [4] = '{4'b0110, 4'b1001, 4'b1000, 4'b1110};
    logic [7:0] fn_y  [4] = '{8'h3C, 8'hC3, 8'hC0, 8'hFC};
    logic [3:0] fn_n  [4] = '{4'd4, 4'd4, 4'd2, 4'd6};
    logic [3:0] ex_op [3] = '{4'b1000, 4'b0000, 4'b1111};
    logic [7:0] ex_y  [3] = '{8'hFF, 8'h00, 8'hFF};
    logic [3:0] ex_n  [3] = '{4'd8, 4'd0, 4'd8};
    function automatic logic [7:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = o[{x[k], z[k]}];
        return r;
    endfunction
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) begin
            b8.in_valid = 1'($urandom); b8.a = 8'($urandom); b8.b = 8'($urandom);
            b8.op = 4'($urandom); b8.out_ready = 1'($urandom);
            @(posedge clk); #1;
            checks += 4;
            if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", b8.out_valid); end
            if (b8.y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", b8.y); end
            if (b8.ones !== 4'd0) begin errors++; $display("FAIL reset_ones: got %0d want 0", b8.ones); end
            if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", b8.in_ready); end
        end
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        rst_n = 1'b1;
    endtask
    task automatic test_functions;
        for (int f = 0; f < 4; f++) begin
            b8.a = 8'hF0; b8.b = 8'hCC; b8.op = fn_op[f]; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
            #1;
            checks++;
            if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL fn%0d_in_ready: got %b want 1", f, b8.in_ready); end
            @(posedge clk); #1;
            b8.in_valid = 1'b0;
            checks++;
            if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL fn%0d_early_valid: got %b want 0", f, b8.out_valid); end
            @(posedge clk); #1;
            checks += 3;
            if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL fn%0d_valid: got %b want 1", f, b8.out_valid); end
            if (b8.y !== fn_y[f]) begin errors++; $display("FAIL fn%0d_y: got %h want %h", f, b8.y, fn_y[f]); end
            if (b8.ones !== fn_n[f]) begin errors++; $display("FAIL fn%0d_ones: got %0d want %0d", f, b8.ones, fn_n[f]); end
            @(posedge clk); #1;
            checks++;
            if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL fn%0d_drained: got %b want 0", f, b8.out_valid); end
        end
    endtask
    task automatic test_exhaustive_1bit;
        logic q[$];
        logic [3:0] o;
        logic e, acc, got;
        int n = 0;
        b1.out_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (c < 64) begin
                o = 4'(c >> 2);
                b1.op = o; b1.a = c[1]; b1.b = c[0]; b1.in_valid = 1'b1;
                e = o[{c[1], c[0]}];
            end else begin
                b1.in_valid = 1'b0;
                e = 1'b0;
            end
            #1;
            acc = b1.in_valid && b1.in_ready;
            @(posedge clk);
            if (acc) q.push_back(e);
            #1;
            if (b1.out_valid === 1'b1) begin
                n++;
                got = (q.size() > 0) ? q.pop_front() : 1'bx;
                checks += 2;
                if (b1.y !== got) begin errors++; $display("FAIL bit_y beat %0d: got %b want %b", n, b1.y, got); end
                if (b1.ones !== b1.y) begin errors++; $display("FAIL bit_ones beat %0d: got %b want %b", n, b1.ones, b1.y); end
            end
        end
        b1.in_valid = 1'b0;
        checks++;
        if (n != 64 || q.size() != 0) begin errors++; $display("FAIL bit_count: got %0d results %0d pending want 64 results 0 pending", n, q.size()); end
    endtask
    task automatic test_back_to_back;
        logic [7:0] sa [20];
        logic [7:0] sb [20];
        logic [3:0] so [20];
        logic [7:0] ey;
        for (int j = 0; j < 20; j++) begin
            sa[j] = 8'(j * 37 + 5); sb[j] = 8'(j * 91 + 3); so[j] = 4'(j * 5 + 1);
        end
        b8.out_ready = 1'b1;
        for (int n = 0; n < 22; n++) begin
            if (n < 20) begin
                b8.a = sa[n]; b8.b = sb[n]; b8.op = so[n]; b8.in_valid = 1'b1;
            end else b8.in_valid = 1'b0;
            #1;
            if (n < 20) begin
                checks++;
                if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d: got %b want 1", n, b8.in_ready); end
            end
            @(posedge clk); #1;
            checks++;
            if (b8.out_valid !== (n >= 1 && n <= 20)) begin
                errors++; $display("FAIL stream_valid edge %0d: got %b want %b", n, b8.out_valid, (n >= 1 && n <= 20));
            end
            if (n >= 1 && n <= 20) begin
                ey = model(so[n-1], sa[n-1], sb[n-1]);
                checks += 2;
                if (b8.y !== ey) begin errors++; $display("FAIL stream_y beat %0d: got %h want %h", n - 1, b8.y, ey); end
                if (b8.ones !== 4'($countones(ey))) begin errors++; $display("FAIL stream_ones beat %0d: got %0d want %0d", n - 1, b8.ones, $countones(ey)); end
            end
        end
    endtask
    task automatic test_backpressure;
        b8.out_ready = 1'b0; b8.a = 8'hF0; b8.b = 8'hCC;
        b8.op = 4'b0110; b8.in_valid = 1'b1;
        #1;
        checks++;
        if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b want 1", b8.in_ready); end
        @(posedge clk); #1;
        b8.op = 4'b1001;
        #1;
        checks++;
        if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b want 1", b8.in_ready); end
        @(posedge clk); #1;
        b8.op = 4'b1000;
        #1;
        checks++;
        if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", b8.in_ready); end
        repeat (3) begin
            @(posedge clk); #1;
            checks += 4;
            if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", b8.out_valid); end
            if (b8.y !== 8'h3C) begin errors++; $display("FAIL bp_hold_y: got %h want 3c", b8.y); end
            if (b8.ones !== 4'd4) begin errors++; $display("FAIL bp_hold_ones: got %0d want 4", b8.ones); end
            if (b8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready: got %b want 0", b8.in_ready); end
        end
        b8.out_ready = 1'b1;
        #1;
        checks++;
        if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", b8.in_ready); end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        checks += 2;
        if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out1_valid: got %b want 1", b8.out_valid); end
        if (b8.y !== 8'hC3) begin errors++; $display("FAIL bp_out1_y: got %h want c3", b8.y); end
        @(posedge clk); #1;
        checks += 2;
        if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out2_valid: got %b want 1", b8.out_valid); end
        if (b8.y !== 8'hC0) begin errors++; $display("FAIL bp_out2_y: got %h want c0", b8.y); end
        @(posedge clk); #1;
        checks++;
        if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", b8.out_valid); end
    endtask
    task automatic test_extremes;
        b8.out_ready = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            if (n < 3) begin b8.op = ex_op[n]; b8.in_valid = 1'b1; end
            else b8.in_valid = 1'b0;
            @(posedge clk); #1;
            if (n >= 1 && n <= 3) begin
                checks += 3;
                if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL ext%0d_valid: got %b want 1", n - 1, b8.out_valid); end
                if (b8.y !== ex_y[n-1]) begin errors++; $display("FAIL ext%0d_y: got %h want %h", n - 1, b8.y, ex_y[n-1]); end
                if (b8.ones !== ex_n[n-1]) begin errors++; $display("FAIL ext%0d_ones: got %0d want %0d", n - 1, b8.ones, ex_n[n-1]); end
            end
        end
    endtask
    task automatic test_reset_midstream;
        logic seen = 1'b0;
        b8.out_ready = 1'b0; b8.a = 8'hF0; b8.b = 8'hCC; b8.op = 4'b0110; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.op = 4'b1001;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        checks++;
        if (b8.out_valid !== 1'b1) begin errors++; $display("FAIL mid_preload: got %b want 1", b8.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", b8.out_valid); end
        if (b8.y !== 8'h00) begin errors++; $display("FAIL mid_y: got %h want 00", b8.y); end
        if (b8.ones !== 4'd0) begin errors++; $display("FAIL mid_ones: got %0d want 0", b8.ones); end
        if (b8.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", b8.in_ready); end
        #1;
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (b8.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_ghost_beat: got %b want 0", seen); end
    endtask
    initial begin
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.op = '0; b8.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.op = '0; b1.out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_functions;
        test_exhaustive_1bit;
        test_back_to_back;
        test_backpressure;
        test_extremes;
        test_reset_midstream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
